// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state encoding and load-result helpers
package mem_ctrl_pkg;

    localparam int          DATA_WIDTH      = 32;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    localparam logic [2:0] MEM_SIZE_BYTE = 3'd1;
    localparam logic [2:0] MEM_SIZE_HALF = 3'd2;
    localparam logic [2:0] MEM_SIZE_WORD = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Requests carry a raw byte count; anything other than 1 or 2 is handled as a full word
    function automatic logic [2:0] norm_size(input logic [5:0] size);
        if (size == 6'd1) begin
            return MEM_SIZE_BYTE;
        end else if (size == 6'd2) begin
            return MEM_SIZE_HALF;
        end
        return MEM_SIZE_WORD;
    endfunction

    // Sign- or zero-extend an assembled little-endian load; bytes above the size are ignored
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                         input logic [2:0]            size,
                                                         input logic                  sign_ext);
        logic [DATA_WIDTH-1:0] res;
        res = raw;
        if (size == MEM_SIZE_BYTE) begin
            res = {{24{sign_ext & raw[7]}}, raw[7:0]};
        end else if (size == MEM_SIZE_HALF) begin
            res = {{16{sign_ext & raw[15]}}, raw[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch, LSB load and ROB store requests onto a byte-wide RAM port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  in_fetcher_ce,
    input  logic [31:0]           in_fetcher_addr,
    output logic                  out_fetcher_ce,
    output logic [DATA_WIDTH-1:0] out_fetcher_data,
    input  logic                  in_lsb_ce,
    input  logic [5:0]            in_lsb_size,
    input  logic                  in_lsb_signed,
    input  logic [31:0]           in_lsb_addr,
    output logic                  out_lsb_ce,
    output logic [DATA_WIDTH-1:0] out_lsb_data,
    input  logic                  in_rob_ce,
    input  logic [5:0]            in_rob_size,
    input  logic [31:0]           in_rob_addr,
    input  logic [DATA_WIDTH-1:0] in_rob_data,
    output logic                  out_rob_ce,
    input  logic                  in_rob_flush
);

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [2:0]            size_r, size_nxt;
    logic [31:0]           base_r, base_nxt;
    logic                  sign_r, sign_nxt;
    logic                  for_fetch, for_fetch_nxt;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_nxt;
    logic [DATA_WIDTH-1:0] rbuf, rbuf_nxt;

    logic                  rob_valid, rob_valid_nxt;
    logic [31:0]           rob_addr, rob_a;
    logic [2:0]            rob_size, rob_s;
    logic [DATA_WIDTH-1:0] rob_data, rob_d;
    logic                  lsb_valid, lsb_valid_nxt;
    logic [31:0]           lsb_addr, lsb_a;
    logic [2:0]            lsb_size, lsb_s;
    logic                  lsb_signed, lsb_sg;
    logic                  fet_valid, fet_valid_nxt;
    logic [31:0]           fet_addr, fet_a;

    logic                  rob_v, lsb_v, fet_v, rob_blocked;
    logic [1:0]            rd_idx;

    logic [7:0]            mem_dout_nxt;
    logic [31:0]           mem_a_nxt;
    logic                  mem_wr_nxt;
    logic                  fetch_ce_nxt, lsb_ce_nxt, rob_ce_nxt;
    logic [DATA_WIDTH-1:0] fetch_data_nxt, lsb_data_nxt;

    // A same-cycle request pulse counts as a valid slot; flush kills load and fetch slots
    always_comb begin
        rob_v       = rob_valid | in_rob_ce;
        rob_a       = in_rob_ce ? in_rob_addr : rob_addr;
        rob_s       = in_rob_ce ? norm_size(in_rob_size) : rob_size;
        rob_d       = in_rob_ce ? in_rob_data : rob_data;
        lsb_v       = (lsb_valid | in_lsb_ce) & ~in_rob_flush;
        lsb_a       = in_lsb_ce ? in_lsb_addr : lsb_addr;
        lsb_s       = in_lsb_ce ? norm_size(in_lsb_size) : lsb_size;
        lsb_sg      = in_lsb_ce ? in_lsb_signed : lsb_signed;
        fet_v       = (fet_valid | in_fetcher_ce) & ~in_rob_flush;
        fet_a       = in_fetcher_ce ? in_fetcher_addr : fet_addr;
        rob_blocked = in_io_buffer_full && (rob_a >= IO_BASE);
    end

    // Next-state, arbitration and next registered outputs for the transfer sequencer
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        size_nxt       = size_r;
        base_nxt       = base_r;
        sign_nxt       = sign_r;
        for_fetch_nxt  = for_fetch;
        wdata_nxt      = wdata_r;
        rbuf_nxt       = rbuf;
        rob_valid_nxt  = rob_v;
        lsb_valid_nxt  = lsb_v;
        fet_valid_nxt  = fet_v;
        mem_a_nxt      = mem_a;
        mem_wr_nxt     = mem_wr;
        mem_dout_nxt   = mem_dout;
        fetch_ce_nxt   = 1'b0;
        lsb_ce_nxt     = 1'b0;
        rob_ce_nxt     = 1'b0;
        fetch_data_nxt = out_fetcher_data;
        lsb_data_nxt   = out_lsb_data;
        rd_idx         = 2'(cnt - 3'd2);

        case (state)
            IDLE: begin
                mem_wr_nxt = 1'b0;
                mem_a_nxt  = '0;
                if (rob_v && !rob_blocked) begin
                    state_nxt     = WRITE;
                    rob_valid_nxt = 1'b0;
                    base_nxt      = rob_a;
                    size_nxt      = rob_s;
                    wdata_nxt     = rob_d;
                    cnt_nxt       = 3'd1;
                    mem_wr_nxt    = 1'b1;
                    mem_a_nxt     = rob_a;
                    mem_dout_nxt  = rob_d[7:0];
                end else if (lsb_v) begin
                    state_nxt     = READ;
                    lsb_valid_nxt = 1'b0;
                    base_nxt      = lsb_a;
                    size_nxt      = lsb_s;
                    sign_nxt      = lsb_sg;
                    for_fetch_nxt = 1'b0;
                    cnt_nxt       = 3'd1;
                    mem_a_nxt     = lsb_a;
                end else if (fet_v) begin
                    state_nxt     = READ;
                    fet_valid_nxt = 1'b0;
                    base_nxt      = fet_a;
                    size_nxt      = MEM_SIZE_WORD;
                    sign_nxt      = 1'b0;
                    for_fetch_nxt = 1'b1;
                    cnt_nxt       = 3'd1;
                    mem_a_nxt     = fet_a;
                end
            end
            READ: begin
                if (in_rob_flush) begin
                    state_nxt  = IDLE;
                    mem_a_nxt  = '0;
                    mem_wr_nxt = 1'b0;
                end else begin
                    if (cnt >= 3'd2) begin
                        rbuf_nxt[{rd_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt == size_r + 3'd1) begin
                        state_nxt = IDLE;
                        mem_a_nxt = '0;
                        if (for_fetch) begin
                            fetch_ce_nxt   = 1'b1;
                            fetch_data_nxt = rbuf_nxt;
                        end else begin
                            lsb_ce_nxt   = 1'b1;
                            lsb_data_nxt = extend_load(rbuf_nxt, size_r, sign_r);
                        end
                    end else begin
                        cnt_nxt   = cnt + 3'd1;
                        mem_a_nxt = (cnt < size_r) ? base_r + {29'd0, cnt} : '0;
                    end
                end
            end
            WRITE: begin
                if (cnt == size_r) begin
                    state_nxt  = IDLE;
                    mem_wr_nxt = 1'b0;
                    mem_a_nxt  = '0;
                    rob_ce_nxt = 1'b1;
                end else begin
                    mem_a_nxt    = base_r + {29'd0, cnt};
                    mem_dout_nxt = wdata_r[{cnt[1:0], 3'b000} +: 8];
                    cnt_nxt      = cnt + 3'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                mem_wr_nxt = 1'b0;
                mem_a_nxt  = '0;
            end
        endcase
    end

    // State, pending slots and all outputs are registered; rdy low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            size_r           <= '0;
            base_r           <= '0;
            sign_r           <= 1'b0;
            for_fetch        <= 1'b0;
            wdata_r          <= '0;
            rbuf             <= '0;
            rob_valid        <= 1'b0;
            rob_addr         <= '0;
            rob_size         <= '0;
            rob_data         <= '0;
            lsb_valid        <= 1'b0;
            lsb_addr         <= '0;
            lsb_size         <= '0;
            lsb_signed       <= 1'b0;
            fet_valid        <= 1'b0;
            fet_addr         <= '0;
            mem_a            <= '0;
            mem_wr           <= 1'b0;
            mem_dout         <= '0;
            out_fetcher_ce   <= 1'b0;
            out_fetcher_data <= '0;
            out_lsb_ce       <= 1'b0;
            out_lsb_data     <= '0;
            out_rob_ce       <= 1'b0;
        end else if (rdy) begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            size_r           <= size_nxt;
            base_r           <= base_nxt;
            sign_r           <= sign_nxt;
            for_fetch        <= for_fetch_nxt;
            wdata_r          <= wdata_nxt;
            rbuf             <= rbuf_nxt;
            rob_valid        <= rob_valid_nxt;
            rob_addr         <= rob_a;
            rob_size         <= rob_s;
            rob_data         <= rob_d;
            lsb_valid        <= lsb_valid_nxt;
            lsb_addr         <= lsb_a;
            lsb_size         <= lsb_s;
            lsb_signed       <= lsb_sg;
            fet_valid        <= fet_valid_nxt;
            fet_addr         <= fet_a;
            mem_a            <= mem_a_nxt;
            mem_wr           <= mem_wr_nxt;
            mem_dout         <= mem_dout_nxt;
            out_fetcher_ce   <= fetch_ce_nxt;
            out_fetcher_data <= fetch_data_nxt;
            out_lsb_ce       <= lsb_ce_nxt;
            out_lsb_data     <= lsb_data_nxt;
            out_rob_ce       <= rob_ce_nxt;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-array RAM and transaction model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_data;
    logic        in_lsb_ce;
    logic [5:0]  in_lsb_size;
    logic        in_lsb_signed;
    logic [31:0] in_lsb_addr;
    logic        out_lsb_ce;
    logic [31:0] out_lsb_data;
    logic        in_rob_ce;
    logic [5:0]  in_rob_size;
    logic [31:0] in_rob_addr;
    logic [31:0] in_rob_data;
    logic        out_rob_ce;
    logic        in_rob_flush;

    typedef struct packed {
        logic        fetch_ce;
        logic [31:0] fetch_addr;
        logic        lsb_ce;
        logic [5:0]  lsb_size;
        logic        lsb_signed;
        logic [31:0] lsb_addr;
        logic        rob_ce;
        logic [5:0]  rob_size;
        logic [31:0] rob_addr;
        logic [31:0] rob_data;
        logic        flush;
    } req_t;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  ram [0:4095];
    logic [7:0]  ref_store [0:255];
    logic [31:0] lsb_q[$];
    logic [31:0] fet_q[$];
    logic [5:0]  size_tab [6] = '{6'd1, 6'd2, 6'd4, 6'd3, 6'd0, 6'd8};

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_io_buffer_full(in_io_buffer_full),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .in_fetcher_ce    (in_fetcher_ce),
        .in_fetcher_addr  (in_fetcher_addr),
        .out_fetcher_ce   (out_fetcher_ce),
        .out_fetcher_data (out_fetcher_data),
        .in_lsb_ce        (in_lsb_ce),
        .in_lsb_size      (in_lsb_size),
        .in_lsb_signed    (in_lsb_signed),
        .in_lsb_addr      (in_lsb_addr),
        .out_lsb_ce       (out_lsb_ce),
        .out_lsb_data     (out_lsb_data),
        .in_rob_ce        (in_rob_ce),
        .in_rob_size      (in_rob_size),
        .in_rob_addr      (in_rob_addr),
        .in_rob_data      (in_rob_data),
        .out_rob_ce       (out_rob_ce),
        .in_rob_flush     (in_rob_flush)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Synchronous byte RAM, 4 KiB aliased over the address space, frozen by rdy like the DUT
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h100] = 8'h13;
        ram[12'h101] = 8'h05;
        ram[12'h102] = 8'h00;
        ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h80;
        ram[12'h210] = 8'h34;
        ram[12'h211] = 8'h12;
        mem_din = 8'h00;
        forever begin
            @(posedge clk);
            if (rdy === 1'b1) begin
                mem_din <= ram[mem_a[11:0]];
                if (mem_wr === 1'b1) ram[mem_a[11:0]] = mem_dout;
            end
        end
    end

    task automatic applyStimulus(input req_t r);
        in_fetcher_ce   = r.fetch_ce;
        in_fetcher_addr = r.fetch_addr;
        in_lsb_ce       = r.lsb_ce;
        in_lsb_size     = r.lsb_size;
        in_lsb_signed   = r.lsb_signed;
        in_lsb_addr     = r.lsb_addr;
        in_rob_ce       = r.rob_ce;
        in_rob_size     = r.rob_size;
        in_rob_addr     = r.rob_addr;
        in_rob_data     = r.rob_data;
        in_rob_flush    = r.flush;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Load value from the byte rules: little-endian assembly, then sign/zero extension
    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [5:0] sz, input logic sg);
        int          n;
        longint      v;
        logic [11:0] idx;
        n = (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
        v = 0;
        for (int k = 0; k < n; k++) begin
            idx = 12'(a + 32'(k));
            v += longint'(ram[idx]) << (8 * k);
        end
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic runLoad(input logic [31:0] a, input logic [5:0] sz, input logic sg,
                           input int n, input logic [31:0] exp, input string tag);
        req_t r;
        r = '0;
        r.lsb_ce = 1'b1; r.lsb_addr = a; r.lsb_size = sz; r.lsb_signed = sg;
        applyStimulus(r);
        for (int c = 1; c <= n + 2; c++) begin
            cyc();
            if (c == 1) begin
                applyStimulus('0);
                checkOutput({tag, "_addr0"}, mem_a, a);
            end
            if (c == n + 1) checkOutput({tag, "_early"}, 32'(out_lsb_ce), 32'd0);
            if (c == n + 2) begin
                checkOutput({tag, "_ce"}, 32'(out_lsb_ce), 32'd1);
                checkOutput({tag, "_data"}, out_lsb_data, exp);
            end
        end
    endtask

    initial begin
        req_t        r;
        int          cnt_f, cnt_l, cnt_r, at_f, at_l, at_r, wr_seen, mism;
        logic        lsb_busy, fet_busy, rob_busy, last_rdy, sg;
        logic [31:0] a, d;
        logic [5:0]  sz;
        int          n;

        rst = 1'b1; rdy = 1'b1; in_io_buffer_full = 1'b0;
        applyStimulus('0);
        repeat (3) cyc();
        checkOutput("rst_mem_a", mem_a, 32'd0);
        checkOutput("rst_ctrl", {26'd0, mem_wr, out_fetcher_ce, out_lsb_ce, out_rob_ce, 2'b00}, 32'd0);
        checkOutput("rst_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("rst_data", out_fetcher_data | out_lsb_data, 32'd0);
        rst = 1'b0;

        $display("[TB] fetch 0x100");
        r = '0; r.fetch_ce = 1'b1; r.fetch_addr = 32'h100;
        applyStimulus(r);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c <= 4) checkOutput("fetch_addr", mem_a, 32'h100 + 32'(c - 1));
            if (c == 5) checkOutput("fetch_early", 32'(out_fetcher_ce), 32'd0);
            if (c == 6) begin
                checkOutput("fetch_ce", 32'(out_fetcher_ce), 32'd1);
                checkOutput("fetch_data", out_fetcher_data, 32'h0000_0513);
            end
            if (c == 7) begin
                checkOutput("fetch_pulse_end", 32'(out_fetcher_ce), 32'd0);
                checkOutput("fetch_data_hold", out_fetcher_data, 32'h0000_0513);
                checkOutput("bus_idle_a", mem_a, 32'd0);
                checkOutput("bus_idle_wr", 32'(mem_wr), 32'd0);
            end
        end

        $display("[TB] loads");
        runLoad(32'h200, 6'd1, 1'b1, 1, 32'hFFFF_FF80, "lb");
        runLoad(32'h200, 6'd1, 1'b0, 1, 32'h0000_0080, "lbu");
        runLoad(32'h210, 6'd2, 1'b0, 2, 32'h0000_1234, "lh");
        runLoad(32'h100, 6'd8, 1'b1, 4, 32'h0000_0513, "lsize8");

        $display("[TB] store word");
        r = '0; r.rob_ce = 1'b1; r.rob_addr = 32'h40; r.rob_size = 6'd4; r.rob_data = 32'hDEAD_BEEF;
        applyStimulus(r);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c <= 4) begin
                checkOutput("sw_wr", 32'(mem_wr), 32'd1);
                checkOutput("sw_addr", mem_a, 32'h40 + 32'(c - 1));
                d = 32'hDEAD_BEEF;
                checkOutput("sw_byte", {24'd0, mem_dout}, {24'd0, d[8 * (c - 1) +: 8]});
            end
            if (c == 5) begin
                checkOutput("sw_wr_end", 32'(mem_wr), 32'd0);
                checkOutput("sw_done", 32'(out_rob_ce), 32'd1);
            end
            if (c == 6) checkOutput("sw_done_end", 32'(out_rob_ce), 32'd0);
        end
        checkOutput("sw_ram", {ram[12'h043], ram[12'h042], ram[12'h041], ram[12'h040]}, 32'hDEAD_BEEF);

        $display("[TB] simultaneous requests");
        r = '0;
        r.rob_ce = 1'b1; r.rob_addr = 32'h44; r.rob_size = 6'd4; r.rob_data = 32'hCAFE_F00D;
        r.lsb_ce = 1'b1; r.lsb_addr = 32'h210; r.lsb_size = 6'd2;
        r.fetch_ce = 1'b1; r.fetch_addr = 32'h100;
        applyStimulus(r);
        cnt_f = 0; cnt_l = 0; cnt_r = 0; at_f = -1; at_l = -1; at_r = -1;
        for (int c = 1; c <= 18; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (out_rob_ce) begin cnt_r++; at_r = c; end
            if (out_lsb_ce) begin cnt_l++; at_l = c; checkOutput("multi_lsb_data", out_lsb_data, 32'h0000_1234); end
            if (out_fetcher_ce) begin cnt_f++; at_f = c; checkOutput("multi_fetch_data", out_fetcher_data, 32'h0000_0513); end
        end
        checkOutput("multi_rob_cycle", 32'(at_r), 32'd5);
        checkOutput("multi_lsb_cycle", 32'(at_l), 32'd9);
        checkOutput("multi_fetch_cycle", 32'(at_f), 32'd15);
        checkOutput("multi_counts", {8'd0, 8'(cnt_r), 8'(cnt_l), 8'(cnt_f)}, 32'h0001_0101);
        checkOutput("multi_ram", {ram[12'h047], ram[12'h046], ram[12'h045], ram[12'h044]}, 32'hCAFE_F00D);

        $display("[TB] flush during load");
        r = '0;
        r.lsb_ce = 1'b1; r.lsb_addr = 32'h800; r.lsb_size = 6'd4;
        r.fetch_ce = 1'b1; r.fetch_addr = 32'h100;
        applyStimulus(r);
        cnt_f = 0; cnt_l = 0; cnt_r = 0; at_r = -1;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c == 3) begin
                r = '0; r.flush = 1'b1;
                r.rob_ce = 1'b1; r.rob_addr = 32'h300; r.rob_size = 6'd1; r.rob_data = 32'h0000_0055;
                applyStimulus(r);
            end
            if (c == 4) begin
                applyStimulus('0);
                checkOutput("flush_bus_a", mem_a, 32'd0);
                checkOutput("flush_bus_wr", 32'(mem_wr), 32'd0);
            end
            if (out_rob_ce) begin cnt_r++; at_r = c; end
            if (out_lsb_ce) cnt_l++;
            if (out_fetcher_ce) cnt_f++;
        end
        checkOutput("flush_no_reads", 32'(cnt_l + cnt_f), 32'd0);
        checkOutput("flush_rob_cycle", 32'(at_r), 32'd6);
        checkOutput("flush_rob_count", 32'(cnt_r), 32'd1);
        checkOutput("flush_ram", {24'd0, ram[12'h300]}, 32'h0000_0055);

        $display("[TB] IO back-pressure");
        in_io_buffer_full = 1'b1;
        r = '0; r.rob_ce = 1'b1; r.rob_addr = 32'h3_0000; r.rob_size = 6'd1; r.rob_data = 32'h0000_00A5;
        applyStimulus(r);
        wr_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c == 5) in_io_buffer_full = 1'b0;
            if (c <= 5 && mem_wr) wr_seen++;
            if (c == 6) begin
                checkOutput("io_wr", 32'(mem_wr), 32'd1);
                checkOutput("io_addr", mem_a, 32'h3_0000);
                checkOutput("io_byte", {24'd0, mem_dout}, 32'h0000_00A5);
            end
            if (c == 7) checkOutput("io_done", {30'd0, out_rob_ce, mem_wr}, 32'd2);
        end
        checkOutput("io_stalled", 32'(wr_seen), 32'd0);

        $display("[TB] reset mid-transfer");
        r = '0; r.fetch_ce = 1'b1; r.fetch_addr = 32'h100;
        applyStimulus(r);
        cnt_f = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst = 1'b0;
                checkOutput("rst_mid_a", mem_a, 32'd0);
            end
            if (out_fetcher_ce) cnt_f++;
        end
        checkOutput("rst_mid_no_done", 32'(cnt_f), 32'd0);

        $display("[TB] rdy stall");
        r = '0; r.fetch_ce = 1'b1; r.fetch_addr = 32'h100;
        applyStimulus(r);
        cnt_f = 0; at_f = -1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) applyStimulus('0);
            if (c == 2) rdy = 1'b0;
            if (c == 3) checkOutput("rdy_hold_a", mem_a, 32'h101);
            if (c == 4) rdy = 1'b1;
            if (out_fetcher_ce) begin cnt_f++; at_f = c; checkOutput("rdy_data", out_fetcher_data, 32'h0000_0513); end
        end
        checkOutput("rdy_done_cycle", 32'(at_f), 32'd8);
        checkOutput("rdy_done_count", 32'(cnt_f), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 256; i++) ref_store[i] = ram[12'(12'hC00 + i)];
        lsb_busy = 1'b0; fet_busy = 1'b0; rob_busy = 1'b0; last_rdy = 1'b1;
        for (int cycn = 0; cycn < 1700; cycn++) begin
            cyc();
            if (last_rdy) begin
                if (out_lsb_ce) begin
                    checkOutput("rnd_lsb_pending", 32'(lsb_q.size()), 32'd1);
                    if (lsb_q.size() > 0) checkOutput("rnd_lsb_data", out_lsb_data, lsb_q.pop_front());
                    lsb_busy = 1'b0;
                end
                if (out_fetcher_ce) begin
                    checkOutput("rnd_fetch_pending", 32'(fet_q.size()), 32'd1);
                    if (fet_q.size() > 0) checkOutput("rnd_fetch_data", out_fetcher_data, fet_q.pop_front());
                    fet_busy = 1'b0;
                end
                if (out_rob_ce) begin
                    checkOutput("rnd_rob_pending", 32'(rob_busy), 32'd1);
                    rob_busy = 1'b0;
                end
            end
            r = '0;
            if (cycn < 1500) begin
                rdy = ($urandom_range(0, 9) != 0);
                if (rdy) begin
                    if ($urandom_range(0, 49) == 0) begin
                        r.flush = 1'b1;
                        lsb_q.delete();
                        fet_q.delete();
                        lsb_busy = 1'b0;
                        fet_busy = 1'b0;
                    end else begin
                        if (!lsb_busy && $urandom_range(0, 4) == 0) begin
                            a = 32'h800 + 32'($urandom_range(0, 240));
                            sz = size_tab[$urandom_range(0, 5)];
                            sg = 1'($urandom);
                            r.lsb_ce = 1'b1; r.lsb_addr = a; r.lsb_size = sz; r.lsb_signed = sg;
                            lsb_q.push_back(refLoad(a, sz, sg));
                            lsb_busy = 1'b1;
                        end
                        if (!fet_busy && $urandom_range(0, 4) == 0) begin
                            a = 32'h800 + 32'($urandom_range(0, 240));
                            r.fetch_ce = 1'b1; r.fetch_addr = a;
                            fet_q.push_back(refLoad(a, 6'd4, 1'b0));
                            fet_busy = 1'b1;
                        end
                    end
                    if (!rob_busy && $urandom_range(0, 5) == 0) begin
                        a = 32'hC00 + 32'($urandom_range(0, 240));
                        sz = size_tab[$urandom_range(0, 5)];
                        d = $urandom;
                        n = (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
                        for (int k = 0; k < n; k++) ref_store[32'(a - 32'hC00) + k] = d[8 * k +: 8];
                        r.rob_ce = 1'b1; r.rob_addr = a; r.rob_size = sz; r.rob_data = d;
                        rob_busy = 1'b1;
                    end
                end
            end else begin
                rdy = 1'b1;
            end
            applyStimulus(r);
            last_rdy = rdy;
        end
        checkOutput("rnd_drained", {29'd0, lsb_busy, fet_busy, rob_busy}, 32'd0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[12'(12'hC00 + i)] !== ref_store[i]) mism++;
        checkOutput("rnd_store_region", 32'(mism), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
